quad_encoder_multi: RTL and testbench

//   Multi-channel quadrature rotary-encoder counter; successor to the single-channel counter toplevel.
//   Per channel: synchroniser, glitch filter, x4/x1 decoder and signed up/down counter (wrap/saturate).
//   Low nibble of a selected channel's count drives a registered hex 7-segment output for the board display.

---
 rtl/quad_encoder_multi_pkg.sv | 51 +++++
 rtl/quad_encoder_multi_if.sv | 35 +++
 rtl/quad_encoder_multi_chan.sv | 83 ++++++++
 rtl/quad_encoder_multi.sv | 58 +++++
 tb/tb_quad_encoder_multi.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/quad_encoder_multi_pkg.sv
// quad_encoder_multi_pkg: quadrature state encodings, step/illegal decode and hex to 7-segment lookup.
package quad_encoder_multi_pkg;

    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S01 = 2'b01;
    localparam logic [1:0] S11 = 2'b11;
    localparam logic [1:0] S10 = 2'b10;

    typedef struct packed {
        logic inc;
        logic dec;
        logic ill;
    } mv_t;

    // In x1 mode only the entries into 00 count, so each detent yields exactly one step.
    function automatic mv_t decode(input logic [1:0] o, input logic [1:0] n, input logic x4);
        mv_t m;
        logic fwd;
        logic rev;
        fwd = (o == S00 && n == S01) || (o == S01 && n == S11) ||
              (o == S11 && n == S10) || (o == S10 && n == S00);
        rev = (o == S01 && n == S00) || (o == S11 && n == S01) ||
              (o == S10 && n == S11) || (o == S00 && n == S10);
        m.ill = (o ^ n) == 2'b11;
        m.inc = fwd && (x4 || o == S10);
        m.dec = rev && (x4 || o == S01);
        return m;
    endfunction

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

endpackage

// File: rtl/quad_encoder_multi_if.sv
// quad_encoder_multi_if: encoder inputs, controls and per-channel results; QUAD_ERR_CNT_EN adds err_cnt.
interface quad_encoder_multi_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
);
    logic [NUM_CH-1:0]       rt_a;
    logic [NUM_CH-1:0]       rt_b;
    logic                    sat_mode;
    logic [NUM_CH-1:0]       clr;
    logic [SEL_W-1:0]        ch_sel;
    logic [NUM_CH*CNT_W-1:0] count;
    logic [NUM_CH-1:0]       step;
    logic [NUM_CH-1:0]       dir;
    logic [6:0]              segments;
`ifdef QUAD_ERR_CNT_EN
    logic [NUM_CH*8-1:0]     err_cnt;
`endif

    modport master (
        output rt_a, rt_b, sat_mode, clr, ch_sel,
        input  count, step, dir, segments
`ifdef QUAD_ERR_CNT_EN
        , input err_cnt
`endif
    );

    modport slave (
        input  rt_a, rt_b, sat_mode, clr, ch_sel,
        output count, step, dir, segments
`ifdef QUAD_ERR_CNT_EN
        , output err_cnt
`endif
    );
endinterface

// File: rtl/quad_encoder_multi_chan.sv
// quad_encoder_multi_chan: one encoder channel (sync, filter, prime, decode, counter); QUAD_ERR_CNT_EN adds err_cnt_o.
module quad_encoder_multi_chan
    import quad_encoder_multi_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int FILT_LEN = 3,
    parameter int RES_X4   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_i,
    input  logic             b_i,
    input  logic             sat_mode_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o,
    output logic             step_o,
    output logic             dir_o
`ifdef QUAD_ERR_CNT_EN
    , output logic [7:0]     err_cnt_o
`endif
);
    localparam logic [CNT_W-1:0] CMAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CMIN = ~CMAX;

    logic [1:0]       s1_q, s2_q, filt_q;
    logic [1:0]       sh_q [FILT_LEN];
    logic             primed_q, step_q, dir_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable, accept, evt, ill, hold;
    mv_t              mv;

    always_comb begin
        stable = 1'b1;
        for (int i = 1; i < FILT_LEN; i++) stable = stable && (sh_q[i] == sh_q[0]);
        accept = stable && (sh_q[0] != filt_q);
        mv     = decode(filt_q, sh_q[0], RES_X4 != 0);
        evt    = accept && primed_q && (mv.inc || mv.dec);
        ill    = accept && primed_q && mv.ill;
        hold   = sat_mode_i && ((mv.inc && cnt_q == CMAX) || (mv.dec && cnt_q == CMIN));
        cnt_d  = clr_i ? '0 : !evt || hold ? cnt_q : mv.inc ? cnt_q + 1'b1 : cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            for (int i = 0; i < FILT_LEN; i++) sh_q[i] <= '0;
            filt_q   <= '0;
            primed_q <= 1'b0;
            cnt_q    <= '0;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
        end else begin
            s1_q    <= {a_i, b_i};
            s2_q    <= s1_q;
            sh_q[0] <= s2_q;
            for (int i = 1; i < FILT_LEN; i++) sh_q[i] <= sh_q[i-1];
            if (accept) begin
                filt_q   <= sh_q[0];
                primed_q <= 1'b1;
            end
            cnt_q  <= cnt_d;
            step_q <= evt && !clr_i;
            if (evt && !clr_i) dir_q <= mv.inc;
        end
    end

`ifdef QUAD_ERR_CNT_EN
    logic [7:0] err_q;
    always_ff @(posedge clk) begin
        if (rst) err_q <= '0;
        else err_q <= clr_i ? '0 : (ill && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end
    assign err_cnt_o = err_q;
`else
    logic unused_ill;
    assign unused_ill = ill;
`endif

    assign count_o = cnt_q;
    assign step_o  = step_q;
    assign dir_o   = dir_q;
endmodule

// File: rtl/quad_encoder_multi.sv
// quad_encoder_multi: NUM_CH quadrature counters plus a registered hex 7-segment view of one channel.
// Define QUAD_ERR_CNT_EN to expose per-channel illegal-transition counters on err_cnt.
module quad_encoder_multi
    import quad_encoder_multi_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 8,
    parameter int FILT_LEN = 3,
    parameter int RES_X4   = 1
) (
    input logic                 clk,
    input logic                 rst,
    quad_encoder_multi_if.slave enc_io
);
    localparam int SEL_W = $clog2(NUM_CH);

    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic [NUM_CH-1:0] step_w, dir_w;
    logic [SEL_W-1:0]  sel;
    logic [6:0]        seg_q, seg_d;
`ifdef QUAD_ERR_CNT_EN
    logic [NUM_CH*8-1:0] err_w;
    assign enc_io.err_cnt = err_w;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        quad_encoder_multi_chan #(
            .CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .RES_X4(RES_X4)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .a_i        (enc_io.rt_a[c]),
            .b_i        (enc_io.rt_b[c]),
            .sat_mode_i (enc_io.sat_mode),
            .clr_i      (enc_io.clr[c]),
            .count_o    (cnt[c]),
            .step_o     (step_w[c]),
            .dir_o      (dir_w[c])
`ifdef QUAD_ERR_CNT_EN
            , .err_cnt_o(err_w[c*8 +: 8])
`endif
        );
        assign enc_io.count[c*CNT_W +: CNT_W] = cnt[c];
    end

    // Out-of-range selections fall back to channel 0.
    assign sel   = (int'(enc_io.ch_sel) < NUM_CH) ? enc_io.ch_sel : '0;
    assign seg_d = hex7(cnt[sel][3:0]);

    always_ff @(posedge clk) begin
        if (rst) seg_q <= 7'h3F;
        else seg_q <= seg_d;
    end

    assign enc_io.step     = step_w;
    assign enc_io.dir      = dir_w;
    assign enc_io.segments = seg_q;
endmodule

// File: tb/tb_quad_encoder_multi.sv
// tb_quad_encoder_multi: directed bench with an x4 and an x1 instance driven from the same encoder inputs.
module tb_quad_encoder_multi;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   steps0 = 0;
    int   steps1 = 0;
    int   s;
    logic [1:0] st0, st1;

    always #5 clk = ~clk;

    quad_encoder_multi_if #(.NUM_CH(2), .CNT_W(8)) bus ();
    quad_encoder_multi_if #(.NUM_CH(2), .CNT_W(8)) bus1 ();

    assign bus1.rt_a     = bus.rt_a;
    assign bus1.rt_b     = bus.rt_b;
    assign bus1.sat_mode = bus.sat_mode;
    assign bus1.clr      = bus.clr;
    assign bus1.ch_sel   = bus.ch_sel;

    quad_encoder_multi #(.NUM_CH(2), .CNT_W(8), .FILT_LEN(3), .RES_X4(1)) dut (
        .clk(clk), .rst(rst), .enc_io(bus));
    quad_encoder_multi #(.NUM_CH(2), .CNT_W(8), .FILT_LEN(3), .RES_X4(0)) dut1 (
        .clk(clk), .rst(rst), .enc_io(bus1));

    always @(posedge clk) begin
        if (bus.step[0]) steps0++;
        if (bus.step[1]) steps1++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] cw(input logic [1:0] v);
        return v == 2'b00 ? 2'b01 : v == 2'b01 ? 2'b11 : v == 2'b11 ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [1:0] ccw(input logic [1:0] v);
        return v == 2'b00 ? 2'b10 : v == 2'b10 ? 2'b11 : v == 2'b11 ? 2'b01 : 2'b00;
    endfunction

    task automatic drive(input int ch, input logic [1:0] ab);
        bus.rt_a[ch] = ab[1];
        bus.rt_b[ch] = ab[0];
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.rt_a = 2'b11;
        bus.rt_b = 2'b11;
        bus.sat_mode = 1'b0;
        bus.clr = 2'b00;
        bus.ch_sel = 1'b0;
        st0 = 2'b11;
        st1 = 2'b11;
        wait_clk(3);
        check("rst_count", bus.count, 16'h0000);
        check("rst_step", bus.step, 2'b00);
        check("rst_dir", bus.dir, 2'b00);
        check("rst_seg", bus.segments, 7'h3F);
        rst = 1'b0;
        wait_clk(12);
        check("prime_count", bus.count, 16'h0000);
        check("prime_steps", steps0 + steps1, 0);
        check("prime_seg", bus.segments, 7'h3F);

        // x4 counting with exact latency on the first edge
        st0 = cw(st0);
        drive(0, st0);
        wait_clk(5);
        check("lat_before", bus.count[7:0], 8'h00);
        wait_clk(1);
        check("lat_count", bus.count[7:0], 8'h01);
        check("lat_step", bus.step[0], 1'b1);
        check("lat_dir", bus.dir[0], 1'b1);
        check("x1_first", bus1.count[7:0], 8'h00);
        wait_clk(1);
        check("step_pulse_end", bus.step[0], 1'b0);
        check("seg_after", bus.segments, 7'h06);
        wait_clk(8);
        for (int i = 0; i < 3; i++) begin
            st0 = cw(st0);
            drive(0, st0);
            wait_clk(10);
        end
        check("x4_count", bus.count[7:0], 8'h04);
        check("x4_steps", steps0, 4);
        check("x4_dir", bus.dir[0], 1'b1);
        check("x4_seg", bus.segments, 7'h66);
        check("x1_count", bus1.count[7:0], 8'h01);
        check("x1_dir", bus1.dir[0], 1'b1);
        check("x1_seg", bus1.segments, 7'h06);

        // reverse direction
        st0 = ccw(st0);
        drive(0, st0);
        wait_clk(10);
        check("ccw1_count", bus.count[7:0], 8'h03);
        check("ccw1_dir", bus.dir[0], 1'b0);
        check("ccw1_x1", bus1.count[7:0], 8'h01);
        st0 = ccw(st0);
        drive(0, st0);
        wait_clk(10);
        check("ccw2_count", bus.count[7:0], 8'h02);
        check("ccw2_x1", bus1.count[7:0], 8'h00);
        check("ccw2_x1_dir", bus1.dir[0], 1'b0);
        for (int i = 0; i < 2; i++) begin
            st0 = cw(st0);
            drive(0, st0);
            wait_clk(10);
        end
        check("back_count", bus.count[7:0], 8'h04);
        check("back_x1", bus1.count[7:0], 8'h00);

        // glitch filter: FILT_LEN-1 cycles rejected, FILT_LEN accepted
        s = steps0;
        bus.rt_a[0] = 1'b0;
        wait_clk(2);
        bus.rt_a[0] = 1'b1;
        wait_clk(10);
        check("glitch_count", bus.count[7:0], 8'h04);
        check("glitch_steps", steps0, s);
        bus.rt_a[0] = 1'b0;
        wait_clk(3);
        bus.rt_a[0] = 1'b1;
        wait_clk(12);
        check("pulse_steps", steps0, s + 2);
        check("pulse_count", bus.count[7:0], 8'h04);
        check("pulse_dir", bus.dir[0], 1'b1);

        // illegal jump: no count, filter still follows
        s = steps0;
        st0 = 2'b00;
        drive(0, st0);
        wait_clk(10);
        check("ill_count", bus.count[7:0], 8'h04);
        check("ill_steps", steps0, s);
        st0 = cw(st0);
        drive(0, st0);
        wait_clk(10);
        check("post_ill_count", bus.count[7:0], 8'h05);
        check("post_ill_seg", bus.segments, 7'h6D);

        // channel 1 to +127, then saturate and wrap
        for (int i = 0; i < 127; i++) begin
            st1 = cw(st1);
            drive(1, st1);
            wait_clk(8);
        end
        check("ch1_max", bus.count[15:8], 8'h7F);
        check("ch1_x1", bus1.count[15:8], 8'h20);
        check("ch0_untouched", bus.count[7:0], 8'h05);
        bus.sat_mode = 1'b1;
        s = steps1;
        st1 = cw(st1);
        drive(1, st1);
        wait_clk(10);
        check("sat_hold", bus.count[15:8], 8'h7F);
        check("sat_step", steps1, s + 1);
        check("sat_dir", bus.dir[1], 1'b1);
        bus.sat_mode = 1'b0;
        st1 = cw(st1);
        drive(1, st1);
        wait_clk(10);
        check("wrap_up", bus.count[15:8], 8'h80);
        st1 = ccw(st1);
        drive(1, st1);
        wait_clk(10);
        check("wrap_down", bus.count[15:8], 8'h7F);
        check("wrap_dir", bus.dir[1], 1'b0);

        // clr coinciding with a step
        st1 = cw(st1);
        drive(1, st1);
        wait_clk(5);
        bus.clr = 2'b10;
        wait_clk(1);
        bus.clr = 2'b00;
        check("clr_count", bus.count[15:8], 8'h00);
        check("clr_step", bus.step[1], 1'b0);
        check("clr_dir", bus.dir[1], 1'b0);
        check("clr_ch0", bus.count[7:0], 8'h05);
        wait_clk(5);
        bus.ch_sel = 1'b1;
        check("sel_before", bus.segments, 7'h6D);
        wait_clk(1);
        check("sel_after", bus.segments, 7'h3F);
        st1 = cw(st1);
        drive(1, st1);
        wait_clk(6);
        check("sel_cnt", bus.count[15:8], 8'h01);
        check("sel_seg_lag", bus.segments, 7'h3F);
        wait_clk(1);
        check("sel_seg", bus.segments, 7'h06);
        wait_clk(5);

        // reset mid-operation, priming repeats
        rst = 1'b1;
        wait_clk(1);
        check("mid_rst_count", bus.count, 16'h0000);
        check("mid_rst_seg", bus.segments, 7'h3F);
        rst = 1'b0;
        s = steps0;
        wait_clk(12);
        check("reprime_count", bus.count[7:0], 8'h00);
        check("reprime_steps", steps0, s);
        st0 = cw(st0);
        drive(0, st0);
        wait_clk(10);
        check("reprime_move", bus.count[7:0], 8'h01);
        check("reprime_dir", bus.dir[0], 1'b1);

`ifdef QUAD_ERR_CNT_EN
        for (int i = 0; i < 300; i++) begin
            st0 = (i % 2 == 0) ? 2'b00 : 2'b11;
            drive(0, st0);
            wait_clk(7);
        end
        check("err_sat", bus.err_cnt[7:0], 8'hFF);
        check("err_ch1", bus.err_cnt[15:8], 8'h00);
        check("err_count", bus.count[7:0], 8'h01);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        check("err_rst", bus.err_cnt, 16'h0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
